// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and constants for the demux dispatch controller
// Purpose: channel-select type, channel count, FSM state and mode encodings.
// Ports: none (package).
package demux_pkg;
  localparam int NUM_CH = 8;

  typedef logic [2:0] ch_sel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_e;
endpackage

// File: rtl/demux_1x8.sv
// rtl/demux_1x8.sv - 1-to-8 data demultiplexer, non-selected channels driven to 0
// Purpose: routes one word to the channel picked by sel_i.
// Ports:
//   sel_i   in   3        selected channel
//   data_i  in   N+1      word to route
//   data_o  out  [7:0][N:0] per-channel data, zero except data_o[sel_i]
module demux_1x8
  import demux_pkg::*;
#(
  parameter int N = 3
) (
  input  ch_sel_t                  sel_i,
  input  logic [N:0]               data_i,
  output logic [NUM_CH-1:0][N:0]   data_o
);

  always_comb begin
    data_o         = '0;
    data_o[sel_i]  = data_i;
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// rtl/demux_dispatch_ctrl.sv - valid/ready dispatcher routing one stream to 8 channels
// Purpose: one-word holding register feeding a 1-to-8 demux; channel chosen by
//   round-robin bursts of BURST_LEN words or a fixed configured channel. A config
//   change drains the held word before the new selection takes effect.
// Optional feature macro: DEMUX_DISPATCH_STATS_EN (per-channel transfer counters).
// Ports:
//   clk_i        in   1          clock, rising edge
//   rst_ni       in   1          synchronous active-low reset
//   data_i       in   N+1        input word
//   valid_i      in   1          input valid
//   ready_o      out  1          input ready
//   mode_i       in   1          0 round-robin, 1 fixed channel
//   fixed_sel_i  in   3          channel used in fixed mode
//   data_o       out  [7:0][N:0] per-channel data
//   valid_o      out  8          per-channel valid (one-hot or zero)
//   ready_i      in   8          per-channel ready
//   sel_o        out  3          channel of the held word
//   busy_o       out  1          controller not idle
//   clr_stats_i  in   1          (stats only) clear transfer counters
//   word_cnt_o   out  [7:0][7:0] (stats only) saturating per-channel transfer counts
module demux_dispatch_ctrl
  import demux_pkg::*;
#(
  parameter int N         = 3,
  parameter int BURST_LEN = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N:0]               data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic                     mode_i,
  input  logic [2:0]               fixed_sel_i,
  output logic [NUM_CH-1:0][N:0]   data_o,
  output logic [NUM_CH-1:0]        valid_o,
  input  logic [NUM_CH-1:0]        ready_i,
  output logic [2:0]               sel_o,
  output logic                     busy_o
`ifdef DEMUX_DISPATCH_STATS_EN
  ,
  input  logic                     clr_stats_i,
  output logic [NUM_CH-1:0][7:0]   word_cnt_o
`endif
);

  logic [N:0] r_data_q;
  logic       r_vld_q;
  ch_sel_t    r_sel_q;
  ch_sel_t    r_ptr;
  logic [3:0] r_bcnt;
  mode_e      r_cfg_mode;
  ch_sel_t    r_cfg_sel;
  state_e     r_state;
  state_e     w_state_nxt;

  logic       w_ready;
  logic       w_accept;
  logic       w_xfer;
  logic       w_vld_nxt;
  logic       w_cfg_change;
  logic       w_drain_done;
  ch_sel_t    w_cur_ptr;

  // Reset forces ready low so nothing is accepted while the register is cleared.
  assign w_ready   = rst_ni && (r_state != DRAIN) && (!r_vld_q || ready_i[r_sel_q]);
  assign w_accept  = valid_i && w_ready;
  assign w_xfer    = r_vld_q && ready_i[r_sel_q];
  assign w_vld_nxt = w_accept || (r_vld_q && !w_xfer);

  // Fixed mode always targets the applied config channel, independent of r_ptr,
  // so a reset in fixed mode dispatches straight to the configured channel.
  assign w_cur_ptr = (r_cfg_mode == MODE_FIXED) ? r_cfg_sel : r_ptr;

  // fixed_sel_i only matters when both the live and applied configs are fixed.
  assign w_cfg_change = (mode_e'(mode_i) != r_cfg_mode) ||
                        ((mode_e'(mode_i) == MODE_FIXED) && (fixed_sel_i != r_cfg_sel));

  assign w_drain_done = (r_state == DRAIN) && !r_vld_q;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_cfg_change)  w_state_nxt = DRAIN;
        else if (w_accept) w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (w_cfg_change)   w_state_nxt = DRAIN;
        else if (!w_vld_nxt) w_state_nxt = IDLE;
      end
      DRAIN: begin
        if (!r_vld_q) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_data_q   <= '0;
      r_vld_q    <= 1'b0;
      r_sel_q    <= '0;
      r_ptr      <= '0;
      r_bcnt     <= '0;
      r_cfg_mode <= mode_e'(mode_i);
      r_cfg_sel  <= fixed_sel_i;
    end else begin
      r_state <= w_state_nxt;
      r_vld_q <= w_vld_nxt;
      if (w_accept) begin
        r_data_q <= data_i;
        r_sel_q  <= w_cur_ptr;
      end
      // Accepts never coincide with drain completion because ready is low in DRAIN.
      if (w_drain_done) begin
        r_cfg_mode <= mode_e'(mode_i);
        r_cfg_sel  <= fixed_sel_i;
        r_bcnt     <= '0;
        if (mode_e'(mode_i) == MODE_FIXED) r_ptr <= fixed_sel_i;
      end else if (w_accept && (r_cfg_mode == MODE_RR)) begin
        if (r_bcnt == 4'(BURST_LEN - 1)) begin
          r_bcnt <= '0;
          r_ptr  <= r_ptr + 3'd1;
        end else begin
          r_bcnt <= r_bcnt + 4'd1;
        end
      end
    end
  end

  demux_1x8 #(.N(N)) u_demux (
    .sel_i  (r_sel_q),
    .data_i (r_data_q),
    .data_o (data_o)
  );

  always_comb begin
    valid_o          = '0;
    valid_o[r_sel_q] = r_vld_q;
  end

  assign ready_o = w_ready;
  assign sel_o   = r_sel_q;
  assign busy_o  = (r_state != IDLE);

`ifdef DEMUX_DISPATCH_STATS_EN
  logic [NUM_CH-1:0][7:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_stats_i) begin
      r_cnt <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (valid_o[c] && ready_i[c] && (r_cnt[c] != 8'hFF)) r_cnt[c] <= r_cnt[c] + 8'd1;
      end
    end
  end

  assign word_cnt_o = r_cnt;
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb/tb_demux_dispatch_ctrl.sv - self-checking bench for demux_dispatch_ctrl
module tb_demux_dispatch_ctrl;
  localparam int N  = 3;
  localparam int BL = 4;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [N:0]       data_i;
  logic             valid_i;
  logic             ready_o;
  logic             mode_i;
  logic [2:0]       fixed_sel_i;
  logic [7:0][N:0]  data_o;
  logic [7:0]       valid_o;
  logic [7:0]       ready_i;
  logic [2:0]       sel_o;
  logic             busy_o;
`ifdef DEMUX_DISPATCH_STATS_EN
  logic             clr_stats_i;
  logic [7:0][7:0]  word_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  demux_dispatch_ctrl #(.N(N), .BURST_LEN(BL)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .mode_i      (mode_i),
    .fixed_sel_i (fixed_sel_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .sel_o       (sel_o),
    .busy_o      (busy_o)
`ifdef DEMUX_DISPATCH_STATS_EN
    ,
    .clr_stats_i (clr_stats_i),
    .word_cnt_o  (word_cnt_o)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: one held word plus the count of accepted words since reset.
  // Round-robin channel of the k-th accepted word is (k / BL) mod 8.
  bit         m_vld;
  logic [N:0] m_data;
  int         m_ch;
  int         m_n;
  bit         m_fixed;
  int         m_fsel;

  task automatic model_reset(input bit fx, input int fs);
    m_vld = 0; m_data = '0; m_ch = 0; m_n = 0; m_fixed = fx; m_fsel = fs;
  endtask

  function automatic logic [31:0] exp_data();
    logic [7:0][N:0] e;
    e = '0;
    e[m_ch] = m_data;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drv(input bit v, input logic [N:0] d, input logic [7:0] rdy);
    valid_i = v; data_i = d; ready_i = rdy;
    #1;
  endtask

  task automatic mcycle(input bit v, input logic [N:0] d, input logic [7:0] rdy);
    bit er, acc, xf;
    logic [7:0] ev;
    drv(v, d, rdy);
    er = !m_vld || rdy[m_ch];
    ev = m_vld ? (8'h1 << m_ch) : 8'h0;
    chk("ready_o", {63'd0, ready_o}, {63'd0, er});
    chk("valid_o", {56'd0, valid_o}, {56'd0, ev});
    chk("data_o", {32'd0, data_o}, {32'd0, exp_data()});
    chk("sel_o", {61'd0, sel_o}, 64'(m_ch));
    acc = v && er;
    xf  = m_vld && rdy[m_ch];
    tick();
    if (acc) begin
      m_vld  = 1;
      m_data = d;
      m_ch   = m_fixed ? m_fsel : ((m_n / BL) % 8);
      m_n++;
    end else if (xf) begin
      m_vld = 0;
    end
  endtask

  task automatic do_reset(input bit md, input logic [2:0] fs);
    rst_ni = 0; mode_i = md; fixed_sel_i = fs; valid_i = 0; data_i = '0; ready_i = 8'hFF;
    tick();
    chk("ready_in_reset", {63'd0, ready_o}, 64'd0);
    tick();
    rst_ni = 1;
    model_reset(md, int'(fs));
  endtask

  typedef struct {
    bit         v;
    logic [N:0] d;
    logic [7:0] rdy;
    bit         e_rdy;
    logic [7:0] e_vld;
    logic [N:0] e_d5;
    bit         e_busy;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // Fixed channel 5 backpressure: A held 3 cycles, then A out and B in together.
    tbl[0] = '{1'b1, 4'hA, 8'hFF, 1'b1, 8'h00, 4'h0, 1'b0};
    tbl[1] = '{1'b1, 4'hB, 8'hDF, 1'b0, 8'h20, 4'hA, 1'b1};
    tbl[2] = '{1'b1, 4'hB, 8'hDF, 1'b0, 8'h20, 4'hA, 1'b1};
    tbl[3] = '{1'b1, 4'hB, 8'hDF, 1'b0, 8'h20, 4'hA, 1'b1};
    tbl[4] = '{1'b1, 4'hB, 8'hFF, 1'b1, 8'h20, 4'hA, 1'b1};
    tbl[5] = '{1'b0, 4'h0, 8'hFF, 1'b1, 8'h20, 4'hB, 1'b1};
    tbl[6] = '{1'b0, 4'h0, 8'hFF, 1'b1, 8'h00, 4'hB, 1'b0};

`ifdef DEMUX_DISPATCH_STATS_EN
    clr_stats_i = 0;
`endif

    // Reset state
    do_reset(1'b0, 3'd0);
    chk("rst_valid_o", {56'd0, valid_o}, 64'd0);
    chk("rst_data_o", {32'd0, data_o}, 64'd0);
    chk("rst_sel_o", {61'd0, sel_o}, 64'd0);
    chk("rst_busy_o", {63'd0, busy_o}, 64'd0);

    // Round-robin bursts, 16 words, full throughput
    for (int i = 0; i < 16; i++) mcycle(1'b1, 4'(i), 8'hFF);
    chk("rr_last_ch3", {56'd0, valid_o}, 64'h08);
    mcycle(1'b0, 4'h0, 8'hFF);
    mcycle(1'b0, 4'h0, 8'hFF);

    // Wrap: words 32..35 land on ch0
    do_reset(1'b0, 3'd0);
    for (int i = 0; i < 36; i++) mcycle(1'b1, 4'(i), 8'hFF);
    chk("wrap_valid_ch0", {56'd0, valid_o}, 64'h01);
    chk("wrap_data_ch0", {60'd0, data_o[0]}, 64'h3);
    mcycle(1'b0, 4'h0, 8'hFF);

    // Randomized round-robin traffic with random per-channel backpressure
    do_reset(1'b0, 3'd0);
    for (int i = 0; i < 400; i++) mcycle(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
    for (int i = 0; i < 3; i++) mcycle(1'b0, 4'h0, 8'hFF);

    // Table-driven backpressure on fixed channel 5
    do_reset(1'b1, 3'd5);
    for (int i = 0; i < 7; i++) begin
      drv(tbl[i].v, tbl[i].d, tbl[i].rdy);
      chk($sformatf("tbl%0d_ready", i), {63'd0, ready_o}, {63'd0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d_valid", i), {56'd0, valid_o}, {56'd0, tbl[i].e_vld});
      chk($sformatf("tbl%0d_data5", i), {60'd0, data_o[5]}, {60'd0, tbl[i].e_d5});
      chk($sformatf("tbl%0d_busy", i), {63'd0, busy_o}, {63'd0, tbl[i].e_busy});
      tick();
    end

    // Config change 2 -> 6 while a word is stuck on ch2
    do_reset(1'b1, 3'd2);
    drv(1'b1, 4'h3, 8'hFB);
    chk("cfg_a_ready", {63'd0, ready_o}, 64'd1);
    tick();
    fixed_sel_i = 3'd6;
    drv(1'b1, 4'h7, 8'hFB);
    chk("cfg_b_ready", {63'd0, ready_o}, 64'd0);
    chk("cfg_b_valid", {56'd0, valid_o}, 64'h04);
    chk("cfg_b_data2", {60'd0, data_o[2]}, 64'h3);
    tick();
    drv(1'b1, 4'h7, 8'hFF);
    chk("cfg_c_busy", {63'd0, busy_o}, 64'd1);
    chk("cfg_c_ready", {63'd0, ready_o}, 64'd0);
    chk("cfg_c_valid", {56'd0, valid_o}, 64'h04);
    chk("cfg_c_sel", {61'd0, sel_o}, 64'd2);
    tick();
    drv(1'b1, 4'h7, 8'hFF);
    chk("cfg_d_ready", {63'd0, ready_o}, 64'd0);
    chk("cfg_d_busy", {63'd0, busy_o}, 64'd1);
    chk("cfg_d_valid", {56'd0, valid_o}, 64'h00);
    tick();
    drv(1'b1, 4'h7, 8'hFF);
    chk("cfg_e_ready", {63'd0, ready_o}, 64'd1);
    chk("cfg_e_busy", {63'd0, busy_o}, 64'd0);
    tick();
    drv(1'b0, 4'h0, 8'hFF);
    chk("cfg_f_valid", {56'd0, valid_o}, 64'h40);
    chk("cfg_f_data6", {60'd0, data_o[6]}, 64'h7);
    chk("cfg_f_sel", {61'd0, sel_o}, 64'd6);
    tick();

    // Reset mid-burst with a word held on ch3
    do_reset(1'b0, 3'd0);
    for (int i = 0; i < 13; i++) mcycle(1'b1, 4'(i), 8'hFF);
    mcycle(1'b0, 4'h0, 8'hF7);
    rst_ni = 0;
    drv(1'b0, 4'h0, 8'hF7);
    chk("midrst_ready", {63'd0, ready_o}, 64'd0);
    tick();
    rst_ni = 1;
    drv(1'b0, 4'h0, 8'hFF);
    chk("postrst_valid", {56'd0, valid_o}, 64'd0);
    chk("postrst_sel", {61'd0, sel_o}, 64'd0);
    chk("postrst_busy", {63'd0, busy_o}, 64'd0);
    model_reset(1'b0, 0);
    mcycle(1'b1, 4'h9, 8'hFF);
    mcycle(1'b0, 4'h0, 8'hFF);
    mcycle(1'b0, 4'h0, 8'hFF);

`ifdef DEMUX_DISPATCH_STATS_EN
    // 300 words to fixed ch1: counter saturates at 255
    do_reset(1'b1, 3'd1);
    for (int i = 0; i < 300; i++) mcycle(1'b1, 4'(i), 8'hFF);
    mcycle(1'b0, 4'h0, 8'hFF);
    mcycle(1'b0, 4'h0, 8'hFF);
    chk("stats_sat", word_cnt_o, 64'h0000_0000_0000_FF00);
    clr_stats_i = 1;
    tick();
    clr_stats_i = 0;
    chk("stats_clr", word_cnt_o, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_dispatch_ctrl.md
Name: demux_dispatch_ctrl

Overview:
- Sequencing controller for the 1-to-8 demultiplexer datapath.
- Accepts one valid/ready input word stream and routes each word to one of 8 output channels, each with its own valid/ready.
- Channel selection is either round-robin in bursts of BURST_LEN words, or a fixed channel from configuration.
- A one-word holding register gives registered outputs. Config changes drain the register before the selector moves.

Parameters:
- N, 3, data width minus 1; word is [N:0].
- BURST_LEN, 4, words sent to one channel before the round-robin pointer advances; legal range 1..16.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_ni  input  1  reset; synchronous, active-low.
- data_i  input  N+1  input word.
- valid_i  input  1  input word valid.
- ready_o  output  1  controller can accept data_i this cycle.
- mode_i  input  1  0 = round-robin, 1 = fixed channel.
- fixed_sel_i  input  3  channel used when mode_i=1.
- data_o  output  [7:0][N:0]  per-channel data; non-selected channels are 0.
- valid_o  output  8  per-channel valid; one-hot or zero.
- ready_i  input  8  per-channel ready.
- sel_o  output  3  channel of the word currently held (sel_q).
- busy_o  output  1  high when state is not IDLE.

Behaviour:
- Registers:
  - data_q[N:0], vld_q, sel_q[2:0] (holding register).
  - ptr[2:0] (next channel).
  - bcnt[3:0] (burst count).
  - cfg_q = {mode_i, fixed_sel_i} (last applied config).
  - state.
- Reset (rst_ni=0 at a clock edge): vld_q=0, data_q=0, sel_q=0, ptr=0, bcnt=0, cfg_q={mode_i, fixed_sel_i}, state=IDLE.
- While rst_ni=0, ready_o is forced to 0.
- After reset: data_o all 0, valid_o=0, sel_o=0, busy_o=0.
- Output decode, combinational from the holding register:
  - data_o[sel_q]=data_q and valid_o[sel_q]=vld_q.
  - All other channels are 0.
- Handshakes:
  - Output transfer on channel c = valid_o[c] & ready_i[c].
  - Input accept = valid_i & ready_o.
  - ready_o = (state != DRAIN) & (!vld_q | ready_i[sel_q]).
  - ready_o depends combinationally on ready_i; no combinational path from valid_i.
- Latency: a word accepted at edge k appears on valid_o/data_o after edge k, i.e. 1 cycle.
- Hold: data_q and sel_q stay stable while vld_q=1 and ready_i[sel_q]=0.
- On accept: data_q=data_i, sel_q=ptr, vld_q=1.
- Output transfer without accept: vld_q=0.
- Accept and output transfer in the same cycle: the register reloads and vld_q stays 1 (full throughput).
- Pointer and burst count:
  - Round-robin (cfg_q mode bit 0): each accept increments bcnt.
  - When an accept occurs with bcnt==BURST_LEN-1: bcnt=0 and ptr=ptr+1, wrapping 7 to 0.
  - Fixed (cfg_q mode bit 1): ptr=cfg_q sel bits; bcnt is unused and held at 0.
- cfg_change = ({mode_i, fixed_sel_i} != cfg_q).
  - In round-robin mode, fixed_sel_i differences are ignored; only a mode_i change counts.
- FSM states:
  - IDLE: vld_q=0.
    - cfg_change -> DRAIN.
    - accept -> ACTIVE.
  - ACTIVE:
    - cfg_change -> DRAIN. An accept in the same cycle is still taken using the old ptr.
    - vld_q would become 0 and no accept -> IDLE.
  - DRAIN: ready_o=0; wait until vld_q=0. Then in one cycle:
    - cfg_q={mode_i, fixed_sel_i}.
    - bcnt=0.
    - ptr = fixed_sel_i if the new mode is fixed, else ptr is unchanged.
    - Go to IDLE.
  - DRAIN entered with vld_q=0 completes in 1 cycle.
- Config changes while in DRAIN are picked up by the final compare. Any mismatch left afterwards triggers a new DRAIN.
- Reset mid-burst or mid-drain: the held word is discarded. No output is produced in the cycle after reset.
- ready_i bits of non-selected channels have no effect.

Optional Feature:
- Macro DEMUX_DISPATCH_STATS_EN.
- When defined, adds output port word_cnt_o [7:0][7:0]: per-channel count of output transfers.
  - Counters saturate at 255 and reset to 0.
  - clr_stats_i (input, 1 bit) zeroes all counters on the next edge; clear has priority over increment in the same cycle.
- When not defined, neither port exists and there is no counter logic.

Decomposition:
- Package demux_pkg holds:
  - typedef ch_sel_t (logic [2:0]);
  - constant NUM_CH=8;
  - enum state_e {IDLE, ACTIVE, DRAIN};
  - typedef mode_e {MODE_RR=0, MODE_FIXED=1}.
- Sub-module: the existing demux_1x8 instance performs the output decode of data_q by sel_q.
  - valid_o is decoded locally.
  - Its N parameter is passed through.

Test Plan:
- Round-robin, BURST_LEN=4, all ready_i=8'hFF, valid_i held high, words 0..15 -> words 0-3 on ch0, 4-7 on ch1, 8-11 on ch2, 12-15 on ch3; one word per cycle; first valid_o one cycle after first accept.
- Round-robin wrap: 36 words -> words 32-35 land on ch0; ptr wraps 7 to 0.
- Backpressure: fixed mode, fixed_sel_i=5, ready_i[5]=0 for 3 cycles while word 4'hA is held -> ready_o=0, data_o[5]=4'hA stable, valid_o=8'h20. ready_i[5]=1 -> transfer, and the next word is accepted in the same cycle.
- Config change mid-stream: fixed_sel_i 2->6 while a word is held on ch2 with ready_i[2]=0 -> state DRAIN, ready_o=0, busy_o=1. After ready_i[2]=1 the word drains, then the next accepted word goes to ch6.
- Reset mid-burst: rst_ni=0 for 1 cycle with vld_q=1 on ch3 -> next cycle valid_o=0, sel_o=0, busy_o=0, ptr=0. A new word goes to ch0.
- With DEMUX_DISPATCH_STATS_EN: send 300 words to fixed ch1 -> word_cnt_o[1]=255, others 0. Pulse clr_stats_i -> all counters 0.
